vpu_inst_buffer: RTL and testbench
==================================

Name: vpu_inst_buffer

Overview:
- Instruction FIFO between the CPU vector-dispatch port and the VPU top-level input (vector_inst_valid_i / vector_inst_i / vector_xrs1_val_i / vector_xrs2_val_i / vector_ack_o).
- Decouples CPU issue from VPU decode back-pressure.
- Counts vector instructions that owe a scalar result, so the CPU can interlock on scalar readback.
- Throttles issue so that count cannot overflow.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- WB_MAX, 3, maximum outstanding scalar-writeback vector instructions; at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- cpu_inst_valid_i  in  1  CPU presents a vector instruction.
- cpu_inst_i  in  32  instruction word.
- cpu_xrs1_i  in  32  scalar rs1 value.
- cpu_xrs2_i  in  32  scalar rs2 value.
- cpu_ready_o  out  1  buffer can accept; equals !full.
- vector_inst_valid_o  out  1  head entry offered to VPU.
- vector_inst_o  out  32  head instruction.
- vector_xrs1_val_o  out  32  head rs1 value.
- vector_xrs2_val_o  out  32  head rs2 value.
- vector_ack_i  in  1  VPU accepted head this cycle.
- vector_writeback_i  in  1  qualifies vector_ack_i: accepted instruction returns a scalar result.
- vector_result_valid_i  in  1  VPU delivered one scalar result to the CPU.
- count_o  out  $clog2(DEPTH)+1  entries held.
- pend_wb_o  out  $clog2(WB_MAX)+1  outstanding scalar-writeback instructions.
- vpu_busy_o  out  1  (count_o != 0) or (pend_wb_o != 0).
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - Pointers, count_o, pend_wb_o and err_o clear to 0; cpu_ready_o=1; vector_inst_valid_o=0; vpu_busy_o=0.
  - Data outputs read 0 (storage cleared).
  - Reset mid-operation discards all entries and pending counts immediately.
- Push = cpu_inst_valid_i && cpu_ready_o. Writes {inst, xrs1, xrs2} at the write pointer; the pointer wraps modulo DEPTH.
- Full (count_o==DEPTH): cpu_ready_o=0. A push offered in the same cycle as a pop is still refused; there is no full-bypass.
- Latency: an entry is visible at the outputs the cycle after its push. There is no empty-bypass. Outputs are driven combinationally from head storage.
- Issue gate: vector_inst_valid_o = (count_o!=0) && !(pend_wb_o==WB_MAX).
- Pop = vector_inst_valid_o && vector_ack_i. Advances the read pointer with modulo wrap.
  - Ack while vector_inst_valid_o=0 is ignored and sets err_o.
- Head outputs are stable until popped; the VPU may hold ack low indefinitely.
- Count update: push only: +1; pop only: -1; push and pop together: unchanged.
- Pending-writeback counter:
  - inc = pop && vector_writeback_i; dec = vector_result_valid_i.
  - inc only: +1; dec only: -1; both: unchanged.
  - dec while pend_wb_o==0 (with no inc): counter stays 0 and err_o is set.
  - The issue gate guarantees inc never occurs at WB_MAX.
- err_o is cleared only by reset.
- Control is a two-state view derived from count_o: EMPTY (count 0) and ACTIVE (count >0).
  - EMPTY->ACTIVE on push.
  - ACTIVE->EMPTY on a pop with count 1 and no push.
  - There is no separate FSM register beyond the counters.

Test Plan:
- Reset then 4 back-to-back pushes (inst 0x0000_1057 + n, xrs1=n, xrs2=0x10+n), with vector_ack_i held 0:
  - count_o steps 1..4; cpu_ready_o=0 after the 4th.
  - The 5th push is refused.
  - vector_inst_o stays 0x0000_1057.
- Full buffer, ack held 1 with cpu_inst_valid_i=1:
  - Outputs drain in order n=0..3, one per cycle.
  - The push in the first pop cycle is refused; the push the next cycle is accepted and emerges 5th.
- Wrap-around, DEPTH=4: 10 pushes interleaved with pops at 1 push + 1 pop per cycle:
  - count_o constant at 1; output order matches input order across pointer wrap.
- Writeback throttle, WB_MAX=3: push 4 instructions, ack each with vector_writeback_i=1:
  - pend_wb_o reaches 3 and vector_inst_valid_o drops with count_o=1.
  - One vector_result_valid_i pulse drops pend_wb_o to 2 and re-raises valid the same cycle.
  - Simultaneous inc and dec leaves pend_wb_o at 2.
- Error and reset:
  - vector_result_valid_i with pend_wb_o=0 sets err_o=1, pend_wb_o stays 0.
  - Ack with an empty buffer keeps err_o=1.
  - Asserting rst_i mid-cycle with 2 entries and pend_wb_o=1 immediately clears count_o, pend_wb_o, err_o, vpu_busy_o and vector_inst_valid_o, and sets cpu_ready_o=1.

Source files
------------

// File: rtl/vpu_inst_buffer.sv
// Vector-instruction FIFO between CPU dispatch and VPU decode. Entries appear one cycle after push.
// The CPU is stalled when the buffer is full, and issue stalls while WB_MAX scalar writebacks are owed.
module vpu_inst_buffer #(
  parameter int DEPTH  = 4,
  parameter int WB_MAX = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cpu_inst_valid_i,
  input  logic [31:0]               cpu_inst_i,
  input  logic [31:0]               cpu_xrs1_i,
  input  logic [31:0]               cpu_xrs2_i,
  output logic                      cpu_ready_o,
  output logic                      vector_inst_valid_o,
  output logic [31:0]               vector_inst_o,
  output logic [31:0]               vector_xrs1_val_o,
  output logic [31:0]               vector_xrs2_val_o,
  input  logic                      vector_ack_i,
  input  logic                      vector_writeback_i,
  input  logic                      vector_result_valid_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [$clog2(WB_MAX):0]   pend_wb_o,
  output logic                      vpu_busy_o,
  output logic                      err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(WB_MAX) + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] xrs1;
    logic [31:0] xrs2;
  } entry_t;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_ACTIVE = 1'b1
  } ctl_e;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] pend_q, pend_d;
  logic          err_q, err_d;
  ctl_e          state;
  logic          full, wb_stall, issue, push, pop, inc, dec;

  // Control state is a view of the occupancy counter, not a separate register.
  always_comb begin
    state = (count_q == '0) ? ST_EMPTY : ST_ACTIVE;
  end

  assign full     = (count_q == CW'(DEPTH));
  assign wb_stall = (pend_q == WW'(WB_MAX));
  assign issue    = (state == ST_ACTIVE) && !wb_stall;
  assign push     = cpu_inst_valid_i && !full;
  assign pop      = issue && vector_ack_i;
  assign inc      = pop && vector_writeback_i;
  assign dec      = vector_result_valid_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pend_d   = pend_q;
    err_d    = err_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A result with nothing owed is a protocol error; the counter saturates at 0.
    if (inc && !dec) begin
      pend_d = pend_q + WW'(1);
    end else if (dec && !inc) begin
      if (pend_q != '0) pend_d = pend_q - WW'(1);
      else              err_d  = 1'b1;
    end

    if (vector_ack_i && !issue) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {cpu_inst_i, cpu_xrs1_i, cpu_xrs2_i};
    end
  end

  assign head                = mem_q[rd_ptr_q];
  assign vector_inst_o       = head.inst;
  assign vector_xrs1_val_o   = head.xrs1;
  assign vector_xrs2_val_o   = head.xrs2;
  assign vector_inst_valid_o = issue;
  assign cpu_ready_o         = !full;
  assign count_o             = count_q;
  assign pend_wb_o           = pend_q;
  assign vpu_busy_o          = (count_q != '0) || (pend_q != '0);
  assign err_o               = err_q;

endmodule

// File: tb/tb_vpu_inst_buffer.sv
// Bench for vpu_inst_buffer: directed sequences, a vector table and a queue-based random model.
module tb_vpu_inst_buffer;

  localparam int DEPTH  = 4;
  localparam int WB_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_v;
  logic [31:0] cpu_inst, cpu_x1, cpu_x2;
  logic        cpu_rdy;
  logic        v_vld;
  logic [31:0] v_inst, v_x1, v_x2;
  logic        ack, wb, res;
  logic [2:0]  count;
  logic [2:0]  pend;
  logic        busy, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vpu_inst_buffer #(.DEPTH(DEPTH), .WB_MAX(WB_MAX)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .cpu_inst_valid_i      (cpu_v),
    .cpu_inst_i            (cpu_inst),
    .cpu_xrs1_i            (cpu_x1),
    .cpu_xrs2_i            (cpu_x2),
    .cpu_ready_o           (cpu_rdy),
    .vector_inst_valid_o   (v_vld),
    .vector_inst_o         (v_inst),
    .vector_xrs1_val_o     (v_x1),
    .vector_xrs2_val_o     (v_x2),
    .vector_ack_i          (ack),
    .vector_writeback_i    (wb),
    .vector_result_valid_i (res),
    .count_o               (count),
    .pend_wb_o             (pend),
    .vpu_busy_o            (busy),
    .err_o                 (err)
  );

  typedef struct {
    logic        v, ack, wb, res;
    logic [31:0] inst;
    logic [2:0]  e_cnt, e_pend;
    logic        e_vld, e_rdy, e_err, chk_head;
    logic [31:0] e_head;
  } vec_t;

  typedef struct {
    logic [31:0] inst, x1, x2;
  } ent_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(int v, int a, int w, int r, int inst, int cnt, int pd,
                              int vld, int rdy, int er, int ch, int head);
    vec_t t;
    t.v = v[0]; t.ack = a[0]; t.wb = w[0]; t.res = r[0];
    t.inst = 32'(inst);
    t.e_cnt = cnt[2:0]; t.e_pend = pd[2:0];
    t.e_vld = vld[0]; t.e_rdy = rdy[0]; t.e_err = er[0];
    t.chk_head = ch[0]; t.e_head = 32'(head);
    return t;
  endfunction

  vec_t tbl [13];
  ent_t mq [$];
  int   m_pend;
  logic m_err;

  initial begin
    // Throttle and error sequence, starting from an empty, error-free buffer.
    //            v a w r inst     cnt pd vld rdy err ch head
    tbl[0]  = mk(1,0,0,0,'h4000,  1, 0, 1, 1, 0, 1,'h4000);
    tbl[1]  = mk(1,0,0,0,'h4001,  2, 0, 1, 1, 0, 1,'h4000);
    tbl[2]  = mk(1,0,0,0,'h4002,  3, 0, 1, 1, 0, 1,'h4000);
    tbl[3]  = mk(1,0,0,0,'h4003,  4, 0, 1, 0, 0, 1,'h4000);
    tbl[4]  = mk(0,1,1,0,0,       3, 1, 1, 1, 0, 1,'h4001);
    tbl[5]  = mk(0,1,1,0,0,       2, 2, 1, 1, 0, 1,'h4002);
    tbl[6]  = mk(0,1,1,0,0,       1, 3, 0, 1, 0, 1,'h4003);
    tbl[7]  = mk(0,0,0,1,0,       1, 2, 1, 1, 0, 1,'h4003);
    tbl[8]  = mk(0,1,1,1,0,       0, 2, 0, 1, 0, 0, 0);
    tbl[9]  = mk(0,0,0,1,0,       0, 1, 0, 1, 0, 0, 0);
    tbl[10] = mk(0,0,0,1,0,       0, 0, 0, 1, 0, 0, 0);
    tbl[11] = mk(0,0,0,1,0,       0, 0, 0, 1, 1, 0, 0);
    tbl[12] = mk(0,1,0,0,0,       0, 0, 0, 1, 1, 0, 0);

    rst = 1'b1; cpu_v = 0; cpu_inst = 0; cpu_x1 = 0; cpu_x2 = 0;
    ack = 0; wb = 0; res = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ready", cpu_rdy, 1);
    chk("rst_valid", v_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_inst", v_inst, 0);
    chk("rst_xrs1", v_x1, 0);
    chk("rst_xrs2", v_x2, 0);
    rst = 1'b0;
    tick();

    // Fill to full with ack held low.
    for (int n = 0; n < 4; n++) begin
      cpu_v = 1; cpu_inst = 32'h1057 + n; cpu_x1 = n; cpu_x2 = 32'h10 + n;
      chk("fill_ready", cpu_rdy, 1);
      tick();
      chk("fill_count", count, n + 1);
      chk("fill_head", v_inst, 32'h1057);
    end
    chk("full_ready", cpu_rdy, 0);
    chk("full_valid", v_vld, 1);
    cpu_inst = 32'h1057 + 4; cpu_x1 = 4; cpu_x2 = 32'h14;
    tick();
    chk("refused_count", count, 4);
    chk("refused_head", v_inst, 32'h1057);

    // Drain with ack high: push refused in first pop cycle, accepted in the next.
    ack = 1;
    for (int k = 0; k < 5; k++) begin
      cpu_v = (k < 2);
      if (k == 0) begin cpu_inst = 32'hDEAD_0000; cpu_x1 = 0; cpu_x2 = 0; end
      else begin cpu_inst = 32'h1057 + 4; cpu_x1 = 4; cpu_x2 = 32'h14; end
      chk("drain_valid", v_vld, 1);
      chk("drain_inst", v_inst, 32'h1057 + k);
      chk("drain_xrs1", v_x1, k);
      chk("drain_xrs2", v_x2, 32'h10 + k);
      chk("drain_ready", cpu_rdy, (k == 0) ? 0 : 1);
      tick();
    end
    ack = 0; cpu_v = 0;
    chk("drain_count", count, 0);
    chk("drain_valid_end", v_vld, 0);
    chk("drain_busy", busy, 0);
    chk("drain_err", err, 0);

    // Wrap-around at one push plus one pop per cycle.
    cpu_v = 1; cpu_inst = 32'h3000; cpu_x1 = 0; cpu_x2 = 32'h100;
    tick();
    chk("wrap_prime", count, 1);
    for (int j = 0; j < 10; j++) begin
      ack = 1; cpu_v = 1;
      cpu_inst = 32'h3000 + j + 1; cpu_x1 = j + 1; cpu_x2 = 32'h100 + j + 1;
      chk("wrap_inst", v_inst, 32'h3000 + j);
      chk("wrap_xrs1", v_x1, j);
      chk("wrap_xrs2", v_x2, 32'h100 + j);
      tick();
      chk("wrap_count", count, 1);
    end
    cpu_v = 0; ack = 1;
    chk("wrap_last", v_inst, 32'h300A);
    tick();
    ack = 0;
    chk("wrap_empty", count, 0);
    chk("wrap_err", err, 0);

    // Vector table: writeback throttle and error behaviour.
    for (int i = 0; i < 13; i++) begin
      cpu_v = tbl[i].v; ack = tbl[i].ack; wb = tbl[i].wb; res = tbl[i].res;
      cpu_inst = tbl[i].inst; cpu_x1 = i; cpu_x2 = 0;
      tick();
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_pend", i), pend, tbl[i].e_pend);
      chk($sformatf("tbl%0d_valid", i), v_vld, tbl[i].e_vld);
      chk($sformatf("tbl%0d_ready", i), cpu_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
      chk($sformatf("tbl%0d_busy", i), busy, (tbl[i].e_cnt != 0) || (tbl[i].e_pend != 0));
      if (tbl[i].chk_head) chk($sformatf("tbl%0d_head", i), v_inst, tbl[i].e_head);
    end
    cpu_v = 0; ack = 0; wb = 0; res = 0;

    // Asynchronous reset mid-cycle with 2 entries and one writeback owed.
    for (int i = 0; i < 3; i++) begin
      cpu_v = 1; cpu_inst = 32'h5000 + i;
      tick();
    end
    cpu_v = 0; ack = 1; wb = 1;
    tick();
    ack = 0; wb = 0;
    chk("pre_rst_count", count, 2);
    chk("pre_rst_pend", pend, 1);
    chk("pre_rst_err", err, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_pend", pend, 0);
    chk("arst_err", err, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", v_vld, 0);
    chk("arst_ready", cpu_rdy, 1);
    chk("arst_inst", v_inst, 0);
    tick();
    rst = 1'b0;
    tick();

    // Random traffic against a queue model.
    m_pend = 0; m_err = 0;
    for (int c = 0; c < 400; c++) begin
      logic m_vld, m_rdy, do_push, do_pop, inc, dec;
      m_vld = (mq.size() != 0) && (m_pend != WB_MAX);
      m_rdy = (mq.size() < DEPTH);
      cpu_v = ($urandom % 3) != 0;
      cpu_inst = $urandom; cpu_x1 = $urandom; cpu_x2 = $urandom;
      ack = (($urandom % 16) == 0) ? 1'($urandom % 2) : (m_vld && (($urandom % 2) == 1));
      wb = 1'($urandom % 2);
      res = (m_pend > 0) ? (($urandom % 3) == 0) : (($urandom % 32) == 0);
      #1;
      chk("rnd_ready", cpu_rdy, m_rdy);
      chk("rnd_valid", v_vld, m_vld);
      chk("rnd_count", count, mq.size());
      chk("rnd_pend", pend, m_pend);
      chk("rnd_err", err, m_err);
      chk("rnd_busy", busy, (mq.size() != 0) || (m_pend != 0));
      if (mq.size() != 0) begin
        chk("rnd_inst", v_inst, mq[0].inst);
        chk("rnd_xrs1", v_x1, mq[0].x1);
        chk("rnd_xrs2", v_x2, mq[0].x2);
      end
      do_push = cpu_v && m_rdy;
      do_pop  = m_vld && ack;
      inc = do_pop && wb;
      dec = res;
      if (ack && !m_vld) m_err = 1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{inst: cpu_inst, x1: cpu_x1, x2: cpu_x2});
      if (inc && !dec) m_pend++;
      else if (dec && !inc) begin
        if (m_pend == 0) m_err = 1;
        else m_pend--;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
